// File: rtl/adder_result_display_pkg.sv
// rtl/adder_result_display_pkg.sv - shared types, constants and double-dabble step
// Purpose: FSM state enumeration, blank glyph, digit count and the BCD
//          shift-add step used by the converter.
// Ports:   none (package).
package adder_result_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    UPDATE
  } state_t;

  localparam logic [6:0] BLANK      = 7'h7F;
  localparam int         NUM_DIGITS = 4;

  // One double-dabble iteration: correct every nibble >= 5 by adding 3,
  // then shift the whole BCD word left, taking bit_in as the new LSB.
  function automatic logic [15:0] dabble_step(input logic [15:0] bcd,
                                              input logic        bit_in);
    logic [15:0] adj;
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return {adj[14:0], bit_in};
  endfunction

endpackage

// File: rtl/adder_result_display_if.sv
// rtl/adder_result_display_if.sv - bus between adder stage and HEX display block
// Purpose: groups the value input, the six HEX digit buses and the busy/done
//          status of the display converter.
// Ports:   master = upstream/testbench side (drives value),
//          slave  = display block (drives HEX0..HEX5, busy, done).
interface adder_result_display_if #(
  parameter int W = 10
);

  logic [W-1:0] value;
  logic [6:0]   HEX0;
  logic [6:0]   HEX1;
  logic [6:0]   HEX2;
  logic [6:0]   HEX3;
  logic [6:0]   HEX4;
  logic [6:0]   HEX5;
  logic         busy;
  logic         done;

  modport master (
    output value,
    input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5,
    input  busy, done
  );

  modport slave (
    input  value,
    output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5,
    output busy, done
  );

endinterface

// File: rtl/bcd7seg.sv
// rtl/bcd7seg.sv - one BCD digit to active-low seven-segment glyph
// Purpose: decodes a decimal digit into segments gfedcba (active low).
// Ports:   digit in (4), blank in (1, forces all segments off), seg out (7).
module bcd7seg
  import adder_result_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = 7'h40;
        4'd1:    seg = 7'h79;
        4'd2:    seg = 7'h24;
        4'd3:    seg = 7'h30;
        4'd4:    seg = 7'h19;
        4'd5:    seg = 7'h12;
        4'd6:    seg = 7'h02;
        4'd7:    seg = 7'h78;
        4'd8:    seg = 7'h00;
        4'd9:    seg = 7'h10;
        // Non-decimal nibbles cannot come out of the converter; show nothing.
        default: seg = BLANK;
      endcase
    end
  end

endmodule

// File: rtl/adder_result_display.sv
// rtl/adder_result_display.sv - binary-to-decimal seven-segment display driver
// Purpose: synchronises an unsigned W-bit value, converts it to BCD with a
//          sequential double-dabble engine and drives four HEX digits with
//          leading-zero blanking. HEX4/HEX5 stay blank.
// Ports:   CLOCK_50 (clock), Resetn (async active-low reset),
//          bus.slave: value in; HEX0..HEX5, busy, done out.
module adder_result_display
  import adder_result_display_pkg::*;
#(
  parameter int W = 10
) (
  input  logic                   CLOCK_50,
  input  logic                   Resetn,
  adder_result_display_if.slave  bus
);

  localparam int CW = $clog2(W + 1);

  state_t                             state;
  logic [W-1:0]                       sync1;
  logic [W-1:0]                       sync2;
  logic [W-1:0]                       last_q;
  logic [W-1:0]                       shift_q;
  logic [1:0]                         fill;
  logic                               pending;
  logic [15:0]                        bcd_q;
  logic [15:0]                        bcd_next;
  logic [CW-1:0]                      cnt;
  logic [NUM_DIGITS-1:0][3:0]         digit_q;
  logic                               busy_q;
  logic                               done_q;
  logic [NUM_DIGITS-1:0]              blank;
  logic [NUM_DIGITS-1:0][6:0]         seg;
  logic                               start;

  assign bcd_next = dabble_step(bcd_q, shift_q[W-1]);

  // fill[1] rises once the synchroniser holds a real post-reset sample, so the
  // pending conversion after reset uses the actual input, not reset zeros.
  assign start = fill[1] && (pending || (sync2 != last_q));

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      sync1   <= '0;
      sync2   <= '0;
      last_q  <= '0;
      shift_q <= '0;
      fill    <= '0;
      pending <= 1'b1;
      bcd_q   <= '0;
      cnt     <= '0;
      digit_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync1  <= bus.value;
      sync2  <= sync1;
      fill   <= {fill[0], 1'b1};
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= LOAD;
            busy_q <= 1'b1;
          end
        end
        LOAD: begin
          shift_q <= sync2;
          last_q  <= sync2;
          bcd_q   <= '0;
          cnt     <= '0;
          pending <= 1'b0;
          state   <= SHIFT;
        end
        SHIFT: begin
          bcd_q   <= bcd_next;
          shift_q <= shift_q << 1;
          if (cnt == CW'(W - 1)) begin
            // Digits take the final step's result directly so the display
            // and done change together on entry to UPDATE.
            digit_q <= bcd_next;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state   <= UPDATE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        UPDATE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A digit blanks when it and every more significant digit are zero;
  // the units digit always shows a glyph.
  always_comb begin
    logic zero_above;
    blank      = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (digit_q[i] == 4'd0);
      blank[i]   = zero_above;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd7seg u_seg (
      .digit (digit_q[g]),
      .blank (blank[g]),
      .seg   (seg[g])
    );
  end

  assign bus.HEX0 = seg[0];
  assign bus.HEX1 = seg[1];
  assign bus.HEX2 = seg[2];
  assign bus.HEX3 = seg[3];
  assign bus.HEX4 = BLANK;
  assign bus.HEX5 = BLANK;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_adder_result_display.sv
// tb/tb_adder_result_display.sv - self-checking bench for adder_result_display
module tb_adder_result_display;

  localparam int W = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #10 clk = ~clk;

  adder_result_display_if #(.W(W)) bus ();

  adder_result_display #(.W(W)) dut (
    .CLOCK_50 (clk),
    .Resetn   (rst_n),
    .bus      (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_total = 0;
  int v_busy_upd = 0;
  int v_hex45 = 0;
  int v_hex_nodone = 0;
  int v_done_wide = 0;
  int cur_value = 0;

  logic [6:0]  glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [27:0] prev_hex;
  logic        prev_done;
  logic [27:0] hex_now;

  assign hex_now = {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};

  // Expected {HEX3,HEX2,HEX1,HEX0} from decimal arithmetic.
  function automatic logic [27:0] model(input int v);
    logic [27:0] r;
    int p;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0 && v < p) r[7*i +: 7] = 7'h7F;
      else                r[7*i +: 7] = glyph[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.done === 1'b1) done_total++;
      if (bus.done === 1'b1 && bus.busy !== 1'b0) v_busy_upd++;
      if (bus.done === 1'b1 && prev_done === 1'b1) v_done_wide++;
      if (hex_now !== prev_hex && bus.done !== 1'b1) v_hex_nodone++;
    end
    if (bus.HEX4 !== 7'h7F || bus.HEX5 !== 7'h7F) v_hex45++;
    prev_hex  <= hex_now;
    prev_done <= bus.done;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (bus.done !== 1'b1 && cycles < budget);
    if (bus.done !== 1'b1) cycles = -1;
  endtask

  task automatic test_reset();
    int lat;
    int base;
    rst_n     = 1'b0;
    bus.value = '0;
    cur_value = 0;
    repeat (3) tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.HEX0 !== 7'h40) begin n_bad++; $display("FAIL reset_hex0: got %h want 40", bus.HEX0); end
    n_cmp++; if (bus.HEX1 !== 7'h7F) begin n_bad++; $display("FAIL reset_hex1: got %h want 7f", bus.HEX1); end
    n_cmp++; if (bus.HEX2 !== 7'h7F) begin n_bad++; $display("FAIL reset_hex2: got %h want 7f", bus.HEX2); end
    n_cmp++; if (bus.HEX3 !== 7'h7F) begin n_bad++; $display("FAIL reset_hex3: got %h want 7f", bus.HEX3); end
    n_cmp++; if (bus.HEX4 !== 7'h7F) begin n_bad++; $display("FAIL reset_hex4: got %h want 7f", bus.HEX4); end
    n_cmp++; if (bus.HEX5 !== 7'h7F) begin n_bad++; $display("FAIL reset_hex5: got %h want 7f", bus.HEX5); end
    base  = done_total;
    rst_n = 1'b1;
    wait_done(40, lat);
    n_cmp++; if (lat !== 14) begin n_bad++; $display("FAIL reset_latency: got %0d want 14", lat); end
    n_cmp++; if (hex_now !== model(0)) begin n_bad++; $display("FAIL reset_zero_hex: got %h want %h", hex_now, model(0)); end
    repeat (20) tick();
    n_cmp++; if (done_total - base !== 1) begin n_bad++; $display("FAIL reset_done_count: got %0d want 1", done_total - base); end
  endtask

  task automatic test_values();
    int lat;
    int vals [3] = '{1023, 7, 10};
    for (int k = 0; k < 3; k++) begin
      bus.value = W'(vals[k]);
      cur_value = vals[k];
      wait_done(40, lat);
      n_cmp++; if (lat !== 14) begin n_bad++; $display("FAIL value_latency %0d: got %0d want 14", vals[k], lat); end
      n_cmp++; if (hex_now !== model(vals[k])) begin n_bad++; $display("FAIL value_hex %0d: got %h want %h", vals[k], hex_now, model(vals[k])); end
      if (k == 0) begin
        n_cmp++; if (hex_now !== {7'h79, 7'h40, 7'h24, 7'h30}) begin n_bad++; $display("FAIL hex_1023: got %h", hex_now); end
      end
      tick();
    end
  endtask

  task automatic test_change_mid_shift();
    int lat;
    int base;
    base      = done_total;
    bus.value = W'(500);
    repeat (8) tick();
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_shift: got %b want 1", bus.busy); end
    bus.value = W'(42);
    cur_value = 42;
    wait_done(20, lat);
    n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL mid_first_latency: got %0d want 6", lat); end
    n_cmp++; if (hex_now !== model(500)) begin n_bad++; $display("FAIL mid_first_hex: got %h want %h", hex_now, model(500)); end
    tick();
    tick();
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_reassert: got %b want 1", bus.busy); end
    wait_done(30, lat);
    n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL mid_second_latency: got %0d want 11", lat); end
    n_cmp++; if (hex_now !== model(42)) begin n_bad++; $display("FAIL mid_second_hex: got %h want %h", hex_now, model(42)); end
    repeat (20) tick();
    n_cmp++; if (done_total - base !== 2) begin n_bad++; $display("FAIL mid_done_count: got %0d want 2", done_total - base); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int base;
    bus.value = W'(777);
    cur_value = 777;
    repeat (6) tick();
    base  = done_total;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rmid_done: got %b want 0", bus.done); end
    n_cmp++; if (hex_now !== model(0)) begin n_bad++; $display("FAIL rmid_hex: got %h want %h", hex_now, model(0)); end
    repeat (4) tick();
    rst_n = 1'b1;
    wait_done(40, lat);
    n_cmp++; if (lat !== 14) begin n_bad++; $display("FAIL rmid_latency: got %0d want 14", lat); end
    n_cmp++; if (hex_now !== model(777)) begin n_bad++; $display("FAIL rmid_hex_after: got %h want %h", hex_now, model(777)); end
    repeat (20) tick();
    n_cmp++; if (done_total - base !== 1) begin n_bad++; $display("FAIL rmid_done_count: got %0d want 1", done_total - base); end
  endtask

  task automatic test_sweep();
    int perm [1024];
    int lat;
    int tmp;
    int j;
    int shown;
    shown = 0;
    for (int i = 0; i < 1024; i++) perm[i] = i;
    for (int i = 1023; i > 0; i--) begin
      j       = int'($urandom_range(i, 0));
      tmp     = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int i = 0; i < 1024; i++) begin
      bus.value = W'(perm[i]);
      if (perm[i] == cur_value) begin
        repeat (16) tick();
      end else begin
        wait_done(40, lat);
        n_cmp++;
        if (lat !== 14) begin
          n_bad++;
          if (shown < 10) $display("FAIL sweep_latency %0d: got %0d want 14", perm[i], lat);
          shown++;
        end
      end
      cur_value = perm[i];
      n_cmp++;
      if (hex_now !== model(perm[i])) begin
        n_bad++;
        if (shown < 10) $display("FAIL sweep_hex %0d: got %h want %h", perm[i], hex_now, model(perm[i]));
        shown++;
      end
      tick();
    end
  endtask

  task automatic test_monitor();
    n_cmp++; if (v_busy_upd !== 0) begin n_bad++; $display("FAIL busy_in_update: got %0d want 0", v_busy_upd); end
    n_cmp++; if (v_hex45 !== 0) begin n_bad++; $display("FAIL hex45_not_blank: got %0d want 0", v_hex45); end
    n_cmp++; if (v_hex_nodone !== 0) begin n_bad++; $display("FAIL hex_change_without_done: got %0d want 0", v_hex_nodone); end
    n_cmp++; if (v_done_wide !== 0) begin n_bad++; $display("FAIL done_wider_than_one: got %0d want 0", v_done_wide); end
  endtask

  initial begin
    test_reset();
    test_values();
    test_change_mid_shift();
    test_reset_mid();
    test_sweep();
    test_monitor();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_result_display.md
ADDER_RESULT_DISPLAY -- requirements
Module: adder_result_display

Interface
REQ-001 The block SHALL have parameter W, default 10, meaning the width of the unsigned binary value displayed (legal range 1..13).
REQ-002 The block SHALL have port CLOCK_50  input  1  the single 50 MHz system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Resetn  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port value  input  W  unsigned result from the upstream adder stage, unsynchronised but stable for many cycles.
REQ-005 The block SHALL have ports HEX0, HEX1, HEX2, HEX3  output  7 each  active-low seven-segment digits, HEX0 least significant decimal digit.
REQ-006 The block SHALL have ports HEX4, HEX5  output  7 each  unused displays, driven blank (7'h7F) at all times.
REQ-007 The block SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse in the cycle the HEX outputs take a new value.

Function
REQ-009 The block SHALL register value through a two-flop synchroniser before any use.
REQ-010 The block SHALL hold a last-converted register and start a conversion whenever the synchronised value differs from it or a pending flag is set.
REQ-011 The block SHALL implement FSM states IDLE, LOAD, SHIFT, UPDATE.
REQ-012 IDLE -> LOAD when a conversion is required; LOAD copies the synchronised value to a shift register and to the last-converted register, clears a 16-bit BCD register and an iteration counter.
REQ-013 SHIFT SHALL perform one double-dabble step per cycle (add 3 to every BCD nibble >= 5, then shift left one bit taking the MSB of the shift register), for exactly W cycles, then go to UPDATE.
REQ-014 UPDATE SHALL load the four digit registers from the BCD register, pulse done, and return to IDLE.
REQ-015 Latency from the synchronised value changing to done SHALL be W+2 cycles (LOAD 1, SHIFT W, UPDATE 1).
REQ-016 busy SHALL be high in LOAD and SHIFT and low in IDLE and UPDATE.
REQ-017 A change of value during LOAD or SHIFT SHALL NOT abort the conversion; the new value SHALL be converted in the next pass, entering LOAD the cycle after UPDATE returns to IDLE.
REQ-018 HEX outputs SHALL change only in the UPDATE cycle; intermediate BCD states SHALL never be visible.
REQ-019 Leading-zero blanking: a digit above the most significant nonzero digit SHALL display blank (7'h7F); HEX0 SHALL always display a glyph, so value 0 shows "0".
REQ-020 Glyphs SHALL be standard active-low segment codes for 0-9 (e.g. 0 = 7'h40, 1 = 7'h79, 8 = 7'h00); codes for BCD nibbles 10-15 SHALL never be produced.
REQ-021 The iteration counter SHALL be ceil(log2(W+1)) bits and SHALL NOT wrap within one conversion.

Reset
REQ-022 Resetn low SHALL force state IDLE, busy 0, done 0, HEX0 = 7'h40, HEX1..HEX5 = 7'h7F, synchroniser, shift, BCD and last-converted registers to 0.
REQ-023 Reset SHALL set the pending flag so one conversion of the current input runs after release, even if the input is 0.
REQ-024 Reset asserted mid-conversion SHALL discard the partial result; no done pulse SHALL follow from the aborted pass.

Structure
REQ-025 A shared package SHALL hold the state enumeration, the BLANK constant 7'h7F, and the digit-count constant 4.
REQ-026 Digit-to-segment decoding SHALL be a sub-module bcd7seg (4-bit digit + blank in, 7-bit active-low segments out), instantiated four times.
REQ-027 The block SHALL sit between the adder top and the DESim HEX port in the testbench, its HEX0..HEX5 mapped to the sim_fpga HEX bus.

Verification
REQ-028 Reset release with value = 0 -> after 2 sync + 12 cycles, done pulses once, HEX0 = 7'h40, HEX1..HEX5 = 7'h7F.
REQ-029 value = 1023 -> done after W+2 = 12 cycles past sync; HEX3..HEX0 = 7'h79, 7'h40, 7'h24, 7'h30 ("1023").
REQ-030 value = 7 then 10 -> "7" with HEX1..HEX3 blank, then "10" with HEX1 = 7'h79, HEX0 = 7'h40, HEX2..HEX3 blank.
REQ-031 value changed 500 -> 42 in the fifth SHIFT cycle -> done shows "500", then busy reasserts next IDLE exit, second done shows "42"; exactly two done pulses.
REQ-032 Resetn pulsed low during SHIFT -> immediate reset values, no done from aborted pass, fresh conversion after release.
REQ-033 Exhaustive sweep 0..1023 compared against a decimal reference model; busy never high in UPDATE; HEX4/HEX5 constant 7'h7F.
